// File: rtl/apb_uart_tx_arbiter_if.sv
// APB bus bundle between the UART TX arbiter (master) and the UART register block (slave).
interface apb_uart_tx_arbiter_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
) ();
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_tx_arbiter.sv
// Two-requester round-robin arbiter that pushes bytes into a UART THR over APB,
// polling LSR.THRE (bit 5) first and dropping the byte after MAX_POLLS busy reads.
module apb_uart_tx_arbiter #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned UART_BASE      = 0,
  parameter int unsigned MAX_POLLS      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic [7:0]            REQ0_DATA,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [7:0]            REQ1_DATA,
  output logic                  REQ1_READY,
  apb_uart_tx_arbiter_if.master apb,
  output logic                  BUSY,
  output logic                  GRANT_ID,
  output logic                  DONE,
  output logic                  DROP
);

  localparam logic [APB_ADDR_WIDTH-1:0] LsrAddr  = APB_ADDR_WIDTH'(UART_BASE + 5);
  localparam logic [APB_ADDR_WIDTH-1:0] ThrAddr  = APB_ADDR_WIDTH'(UART_BASE);
  localparam logic [7:0]                MaxPolls = 8'(MAX_POLLS);

  typedef enum logic [2:0] {
    StIdle,
    StLsrSetup,
    StLsrAccess,
    StThrSetup,
    StThrAccess
  } state_e;

  state_e                    state_q, state_d;
  logic [7:0]                byte_q, byte_d;
  logic                      grant_q, grant_d;
  logic                      last_q, last_d;
  logic [7:0]                poll_q, poll_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      done_q, done_d;
  logic                      drop_q, drop_d;

  logic       sel;
  logic [7:0] poll_inc;
  logic       unused_prdata;

  // Only THRE matters; the other LSR bits are intentionally ignored.
  assign unused_prdata = ^{apb.PRDATA[31:6], apb.PRDATA[4:0]};

  // With both valid, the requester not served last wins; otherwise the lone valid one.
  assign sel      = (REQ0_VALID && REQ1_VALID) ? ~last_q : REQ1_VALID;
  assign poll_inc = poll_q + 8'd1;

  // Next-state, registered APB values and combinational ready handshake.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    grant_d    = grant_q;
    last_d     = last_q;
    poll_d     = poll_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!RST && (REQ0_VALID || REQ1_VALID)) begin
          REQ0_READY = ~sel;
          REQ1_READY = sel;
          byte_d     = sel ? REQ1_DATA : REQ0_DATA;
          grant_d    = sel;
          last_d     = sel;
          poll_d     = 8'd0;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = 1'b0;
          paddr_d    = LsrAddr;
          state_d    = StLsrSetup;
        end
      end
      StLsrSetup: begin
        penable_d = 1'b1;
        state_d   = StLsrAccess;
      end
      StLsrAccess: begin
        if (apb.PREADY) begin
          penable_d = 1'b0;
          if (!apb.PSLVERR && apb.PRDATA[5]) begin
            pwrite_d = 1'b1;
            paddr_d  = ThrAddr;
            pwdata_d = {24'b0, byte_q};
            state_d  = StThrSetup;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == MaxPolls) begin
              drop_d  = 1'b1;
              psel_d  = 1'b0;
              state_d = StIdle;
            end else begin
              state_d = StLsrSetup;
            end
          end
        end
      end
      StThrSetup: begin
        penable_d = 1'b1;
        state_d   = StThrAccess;
      end
      StThrAccess: begin
        if (apb.PREADY) begin
          done_d    = ~apb.PSLVERR;
          drop_d    = apb.PSLVERR;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight byte silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      byte_q    <= 8'd0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      poll_q    <= 8'd0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= 32'd0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      poll_q    <= poll_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign BUSY        = (state_q != StIdle);
  assign GRANT_ID    = grant_q;
  assign DONE        = done_q;
  assign DROP        = drop_q;

endmodule
